// File: rtl/wb_mctrl_arb_if.sv
// WISHBONE bus bundle shared by the two arbiter masters and the wb_mctrl slave port.
// master modport: the side that initiates cycles; slave modport: the side that terminates them.
interface wb_mctrl_arb_if;
  localparam int unsigned ADR_W = 32;
  localparam int unsigned DAT_W = 32;
  localparam int unsigned SEL_W = 4;
  localparam int unsigned CTI_W = 3;
  localparam int unsigned BTE_W = 2;

  logic [ADR_W-1:0] adr;
  logic [DAT_W-1:0] dat_w;
  logic [DAT_W-1:0] dat_r;
  logic [SEL_W-1:0] sel;
  logic             cyc;
  logic             stb;
  logic             we;
  logic [CTI_W-1:0] cti;
  logic [BTE_W-1:0] bte;
  logic             ack;
  logic             err;
  logic             rty;

  modport master (
    output adr, dat_w, sel, cyc, stb, we, cti, bte,
    input  dat_r, ack, err, rty
  );

  modport slave (
    input  adr, dat_w, sel, cyc, stb, we, cti, bte,
    output dat_r, ack, err, rty
  );
endinterface

// File: rtl/wb_mctrl_arb.sv
// Two-master round-robin WISHBONE arbiter in front of the wb_mctrl main slave port.
// m0 is the instruction-fetch master, m1 the data master. The grant is held for the
// whole cyc, so classic and incrementing bursts are never split between masters.
// Optional unanswered-strobe watchdog: define WB_MCTRL_ARB_WATCHDOG_EN to build it.
module wb_mctrl_arb #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  wb_mctrl_arb_if.slave       m0,
  wb_mctrl_arb_if.slave       m1,
  wb_mctrl_arb_if.master      s,
  output logic [1:0]          gnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t state;
  logic   rr_last;   // index of the master that owned the bus last
  logic   stb_mux;   // owner's strobe before any watchdog masking
  logic   wd_fire;   // watchdog terminates the current strobe this cycle

  // Elaboration-time sanity check of the watchdog sizing.
  if ((TIMEOUT == 0) || (64'(TIMEOUT) >= (64'(1) << CNT_W))) begin : g_cfg_bad
    $error("wb_mctrl_arb: TIMEOUT must be in 1 .. 2**CNT_W-1");
  end

  // Arbitration FSM: pick an owner from IDLE, hold it until its cyc drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rr_last <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (m0.cyc && m1.cyc) begin
            state <= rr_last ? OWN0 : OWN1;
          end else if (m0.cyc) begin
            state <= OWN0;
          end else if (m1.cyc) begin
            state <= OWN1;
          end
        end
        OWN0: begin
          if (!m0.cyc) begin
            rr_last <= 1'b0;
            state   <= m1.cyc ? OWN1 : IDLE;
          end
        end
        OWN1: begin
          if (!m1.cyc) begin
            rr_last <= 1'b1;
            state   <= m0.cyc ? OWN0 : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // One-hot grant decoded straight from the state register.
  assign gnt_o = {state == OWN1, state == OWN0};

  // Owner's raw strobe; kept separate so the watchdog never loops through s.stb.
  assign stb_mux = (state == OWN0) ? m0.stb :
                   (state == OWN1) ? m1.stb : 1'b0;

`ifdef WB_MCTRL_ARB_WATCHDOG_EN
  logic             term;
  logic [CNT_W-1:0] wd_cnt;

  assign term    = s.ack | s.err | s.rty;
  assign wd_fire = stb_mux && !term && (wd_cnt == CNT_W'(TIMEOUT - 1));

  // Count consecutive unanswered strobe cycles; clear on answer, idle or firing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (wd_fire || !stb_mux || term) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + CNT_W'(1);
    end
  end
`else
  assign wd_fire = 1'b0;
`endif

  // Request mux towards the slave and termination routing back to the owner only.
  always_comb begin
    s.adr   = m0.adr;
    s.dat_w = m0.dat_w;
    s.sel   = m0.sel;
    s.we    = m0.we;
    s.cti   = m0.cti;
    s.bte   = m0.bte;
    s.cyc   = 1'b0;
    s.stb   = stb_mux & ~wd_fire;

    m0.dat_r = s.dat_r;
    m1.dat_r = s.dat_r;
    m0.ack   = 1'b0;
    m0.err   = 1'b0;
    m0.rty   = 1'b0;
    m1.ack   = 1'b0;
    m1.err   = 1'b0;
    m1.rty   = 1'b0;

    case (state)
      OWN0: begin
        s.cyc  = m0.cyc;
        m0.ack = s.ack;
        m0.err = s.err | wd_fire;
        m0.rty = s.rty;
      end
      OWN1: begin
        s.adr   = m1.adr;
        s.dat_w = m1.dat_w;
        s.sel   = m1.sel;
        s.we    = m1.we;
        s.cti   = m1.cti;
        s.bte   = m1.bte;
        s.cyc   = m1.cyc;
        m1.ack  = s.ack;
        m1.err  = s.err | wd_fire;
        m1.rty  = s.rty;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_mctrl_arb.sv
// Scoreboard bench for wb_mctrl_arb: tests push expected grants/terminations,
// a negedge monitor pops and compares whenever the DUT presents one.
module tb_wb_mctrl_arb;

  localparam int unsigned TO = 16;
  localparam logic [31:0] RD_XOR = 32'h9EAD_BEEF;  // slave read data = adr ^ RD_XOR

  localparam logic [5:0] M0_ACK = 6'b000001;
  localparam logic [5:0] M0_ERR = 6'b000010;
  localparam logic [5:0] M0_RTY = 6'b000100;
  localparam logic [5:0] M1_ACK = 6'b001000;
  localparam logic [5:0] M1_ERR = 6'b010000;
  localparam logic [5:0] M1_RTY = 6'b100000;

  typedef struct packed {
    logic [5:0]  term;
    logic        stb;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic        we;
    logic [2:0]  cti;
    logic [31:0] dat_r;
  } obs_t;

  logic clk;
  logic rst;
  logic [1:0] gnt;
  logic [1:0] slave_kind;  // 0 silent, 1 ack, 2 err, 3 rty

  logic        m_cyc [2];
  logic        m_stb [2];
  logic        m_we  [2];
  logic [31:0] m_adr [2];
  logic [31:0] m_dat [2];
  logic [2:0]  m_cti [2];
  logic        m_ack [2];
  logic        m_err [2];
  logic        m_rty [2];

  int n_cmp;
  int n_bad;
  obs_t       exp_q [$];
  logic [1:0] exp_gnt_q [$];
  logic [1:0] prev_gnt;
  int lat0;
  int lat1;

  wb_mctrl_arb_if m0_if ();
  wb_mctrl_arb_if m1_if ();
  wb_mctrl_arb_if s_if ();

  wb_mctrl_arb #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .m0    (m0_if.slave),
    .m1    (m1_if.slave),
    .s     (s_if.master),
    .gnt_o (gnt)
  );

  assign m0_if.adr = m_adr[0];  assign m1_if.adr = m_adr[1];
  assign m0_if.dat_w = m_dat[0]; assign m1_if.dat_w = m_dat[1];
  assign m0_if.sel = 4'hF;      assign m1_if.sel = 4'hF;
  assign m0_if.cyc = m_cyc[0];  assign m1_if.cyc = m_cyc[1];
  assign m0_if.stb = m_stb[0];  assign m1_if.stb = m_stb[1];
  assign m0_if.we  = m_we[0];   assign m1_if.we  = m_we[1];
  assign m0_if.cti = m_cti[0];  assign m1_if.cti = m_cti[1];
  assign m0_if.bte = 2'b00;     assign m1_if.bte = 2'b00;
  assign m_ack[0] = m0_if.ack;  assign m_ack[1] = m1_if.ack;
  assign m_err[0] = m0_if.err;  assign m_err[1] = m1_if.err;
  assign m_rty[0] = m0_if.rty;  assign m_rty[1] = m1_if.rty;

  // Zero-wait slave: answers whenever a cycle is presented, per slave_kind.
  assign s_if.ack   = s_if.cyc & (slave_kind == 2'd1);
  assign s_if.err   = s_if.cyc & (slave_kind == 2'd2);
  assign s_if.rty   = s_if.cyc & (slave_kind == 2'd3);
  assign s_if.dat_r = s_if.adr ^ RD_XOR;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t mk(input logic [5:0] t, input logic stb, input logic [31:0] adr,
                              input logic we, input logic [2:0] cti);
    obs_t o;
    o.term  = t;
    o.stb   = stb;
    o.adr   = adr;
    o.dat_w = ~adr;
    o.we    = we;
    o.cti   = cti;
    o.dat_r = adr ^ RD_XOR;
    return o;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Master driver: beats back to back, each beat held until answered or bound expires.
  task automatic m_xfer(input int idx, input logic [31:0] adr, input logic we, input int beats,
                        input logic [2:0] last_cti, input bit exp_to, output int lat);
    bit got;
    bit to;
    int n;
    to  = 1'b0;
    lat = 0;
    for (int b = 0; b < beats; b++) begin
      m_adr[idx] = adr + 32'(4 * b);
      m_dat[idx] = ~(adr + 32'(4 * b));
      m_we[idx]  = we;
      m_cti[idx] = (b == beats - 1) ? last_cti : 3'b010;
      m_cyc[idx] = 1'b1;
      m_stb[idx] = 1'b1;
      got = 1'b0;
      n   = 0;
      while (!got && n < 60) begin
        @(negedge clk);
        n++;
        if (m_ack[idx] || m_err[idx] || m_rty[idx]) got = 1'b1;
      end
      lat = n;
      @(posedge clk);
      #1;
      if (!got) begin
        to = 1'b1;
        break;
      end
    end
    m_cyc[idx] = 1'b0;
    m_stb[idx] = 1'b0;
    m_cti[idx] = 3'b000;
    chk($sformatf("m%0d_timeout", idx), 64'(to), 64'(exp_to));
  endtask

  // Monitor: compare every grant change and every termination against the queues.
  always @(negedge clk) begin
    obs_t a;
    obs_t e;
    logic [1:0] eg;
    a.term  = {m1_if.rty, m1_if.err, m1_if.ack, m0_if.rty, m0_if.err, m0_if.ack};
    a.stb   = s_if.stb;
    a.adr   = s_if.adr;
    a.dat_w = s_if.dat_w;
    a.we    = s_if.we;
    a.cti   = s_if.cti;
    a.dat_r = (a.term[5:3] != 3'b000) ? m1_if.dat_r : m0_if.dat_r;
    if (a.term != 6'b0) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_term: got %h expected none (t=%0t)", a, $time);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          n_bad++;
          $display("FAIL term: got %h expected %h (t=%0t)", a, e, $time);
        end
      end
    end
    if (gnt !== prev_gnt) begin
      n_cmp++;
      if (exp_gnt_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_gnt: got %b expected no change (t=%0t)", gnt, $time);
      end else begin
        eg = exp_gnt_q.pop_front();
        if (gnt !== eg) begin
          n_bad++;
          $display("FAIL gnt: got %b expected %b (t=%0t)", gnt, eg, $time);
        end
      end
      prev_gnt = gnt;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    prev_gnt = 2'b00;
    slave_kind = 2'd1;
    for (int i = 0; i < 2; i++) begin
      m_cyc[i] = 1'b0; m_stb[i] = 1'b0; m_we[i] = 1'b0;
      m_dat[i] = '0;   m_cti[i] = 3'b000;
    end
    m_adr[0] = 32'h1111_0000;
    m_adr[1] = 32'h2222_0000;
    rst = 1'b1;

    // Reset state, with m0 already requesting.
    m_cyc[0] = 1'b1;
    m_stb[0] = 1'b1;
    idle(2);
    chk("rst_gnt", 64'(gnt), 64'(2'b00));
    chk("rst_s_cyc_stb", 64'({s_if.cyc, s_if.stb}), 64'(2'b00));
    chk("rst_terms", 64'({m1_if.rty, m1_if.err, m1_if.ack, m0_if.rty, m0_if.err, m0_if.ack}), 64'(0));
    chk("rst_adr_follows_m0", 64'(s_if.adr), 64'(32'h1111_0000));
    m_cyc[0] = 1'b0;
    m_stb[0] = 1'b0;
    idle(1);
    rst = 1'b0;
    idle(2);

    // Simultaneous requests after reset: m0 first, then m1 with no idle cycle.
    exp_gnt_q.push_back(2'b01); exp_gnt_q.push_back(2'b10); exp_gnt_q.push_back(2'b00);
    exp_q.push_back(mk(M0_ACK, 1'b1, 32'h0000_1000, 1'b0, 3'b000));
    exp_q.push_back(mk(M1_ACK, 1'b1, 32'h0000_2000, 1'b0, 3'b000));
    fork
      m_xfer(0, 32'h0000_1000, 1'b0, 1, 3'b000, 1'b0, lat0);
      m_xfer(1, 32'h0000_2000, 1'b0, 1, 3'b000, 1'b0, lat1);
    join
    idle(3);

    // m0 alone reads 0x4000_0000; slave returns 0xDEADBEEF one cycle after the request.
    exp_gnt_q.push_back(2'b01); exp_gnt_q.push_back(2'b00);
    exp_q.push_back('{term: M0_ACK, stb: 1'b1, adr: 32'h4000_0000, dat_w: 32'hBFFF_FFFF,
                      we: 1'b0, cti: 3'b000, dat_r: 32'hDEAD_BEEF});
    m_xfer(0, 32'h4000_0000, 1'b0, 1, 3'b000, 1'b0, lat0);
    chk("m0_alone_latency", 64'(lat0), 64'(2));
    idle(3);

    // m1 alone: write answered with err, then read answered with rty.
    slave_kind = 2'd2;
    exp_gnt_q.push_back(2'b10); exp_gnt_q.push_back(2'b00);
    exp_q.push_back(mk(M1_ERR, 1'b1, 32'h0000_8000, 1'b1, 3'b000));
    m_xfer(1, 32'h0000_8000, 1'b1, 1, 3'b000, 1'b0, lat1);
    idle(3);
    slave_kind = 2'd3;
    exp_gnt_q.push_back(2'b10); exp_gnt_q.push_back(2'b00);
    exp_q.push_back(mk(M1_RTY, 1'b1, 32'h0000_8800, 1'b0, 3'b000));
    m_xfer(1, 32'h0000_8800, 1'b0, 1, 3'b000, 1'b0, lat1);
    idle(3);
    slave_kind = 2'd1;

    // m0 4-beat incrementing burst while m1 requests throughout; m1 waits for release.
    exp_gnt_q.push_back(2'b01); exp_gnt_q.push_back(2'b10); exp_gnt_q.push_back(2'b00);
    exp_q.push_back(mk(M0_ACK, 1'b1, 32'h0000_0100, 1'b0, 3'b010));
    exp_q.push_back(mk(M0_ACK, 1'b1, 32'h0000_0104, 1'b0, 3'b010));
    exp_q.push_back(mk(M0_ACK, 1'b1, 32'h0000_0108, 1'b0, 3'b010));
    exp_q.push_back(mk(M0_ACK, 1'b1, 32'h0000_010C, 1'b0, 3'b111));
    exp_q.push_back(mk(M1_ACK, 1'b1, 32'h2000_0000, 1'b1, 3'b000));
    fork
      m_xfer(0, 32'h0000_0100, 1'b0, 4, 3'b111, 1'b0, lat0);
      m_xfer(1, 32'h2000_0000, 1'b1, 1, 3'b000, 1'b0, lat1);
    join
    idle(3);

    // Back-to-back singles from both masters: grants alternate 01,10,01,10.
    exp_gnt_q.push_back(2'b01); exp_gnt_q.push_back(2'b10);
    exp_gnt_q.push_back(2'b01); exp_gnt_q.push_back(2'b10); exp_gnt_q.push_back(2'b00);
    exp_q.push_back(mk(M0_ACK, 1'b1, 32'h0000_3000, 1'b0, 3'b000));
    exp_q.push_back(mk(M1_ACK, 1'b1, 32'h0000_4000, 1'b1, 3'b000));
    exp_q.push_back(mk(M0_ACK, 1'b1, 32'h0000_3010, 1'b0, 3'b000));
    exp_q.push_back(mk(M1_ACK, 1'b1, 32'h0000_4010, 1'b1, 3'b000));
    fork
      begin
        m_xfer(0, 32'h0000_3000, 1'b0, 1, 3'b000, 1'b0, lat0);
        idle(1);
        m_xfer(0, 32'h0000_3010, 1'b0, 1, 3'b000, 1'b0, lat0);
      end
      begin
        m_xfer(1, 32'h0000_4000, 1'b1, 1, 3'b000, 1'b0, lat1);
        idle(1);
        m_xfer(1, 32'h0000_4010, 1'b1, 1, 3'b000, 1'b0, lat1);
      end
    join
    idle(3);

    // Silent slave: watchdog terminates the strobe, or the owner stalls without err.
    slave_kind = 2'd0;
    exp_gnt_q.push_back(2'b01); exp_gnt_q.push_back(2'b00);
`ifdef WB_MCTRL_ARB_WATCHDOG_EN
    exp_q.push_back(mk(M0_ERR, 1'b0, 32'h0000_7000, 1'b0, 3'b000));
    m_xfer(0, 32'h0000_7000, 1'b0, 1, 3'b000, 1'b0, lat0);
    chk("wd_err_latency", 64'(lat0), 64'(TO + 1));
`else
    fork
      m_xfer(0, 32'h0000_7000, 1'b0, 1, 3'b000, 1'b1, lat0);
      begin
        repeat (20) @(negedge clk);
        chk("stall_stb_err", 64'({s_if.stb, m0_if.err, gnt}), 64'({1'b1, 1'b0, 2'b01}));
      end
    join
`endif
    slave_kind = 2'd1;
    idle(3);

    // Async reset in beat 2 of a burst, then a tie that m0 must win again.
    exp_gnt_q.push_back(2'b01); exp_gnt_q.push_back(2'b00);
    exp_gnt_q.push_back(2'b01); exp_gnt_q.push_back(2'b10); exp_gnt_q.push_back(2'b00);
    exp_q.push_back(mk(M0_ACK, 1'b1, 32'h0000_5000, 1'b0, 3'b010));
    exp_q.push_back(mk(M0_ACK, 1'b1, 32'h0000_5100, 1'b0, 3'b000));
    exp_q.push_back(mk(M1_ACK, 1'b1, 32'h0000_6100, 1'b0, 3'b000));
    m_adr[0] = 32'h0000_5000; m_dat[0] = ~32'h0000_5000; m_we[0] = 1'b0;
    m_cti[0] = 3'b010; m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    idle(2);
    m_adr[0] = 32'h0000_5004; m_dat[0] = ~32'h0000_5004;
    #1 rst = 1'b1;
    #1;
    chk("async_rst_s_cyc_stb", 64'({s_if.cyc, s_if.stb}), 64'(2'b00));
    chk("async_rst_gnt", 64'(gnt), 64'(2'b00));
    chk("async_rst_no_term", 64'({m0_if.ack, m0_if.err, m0_if.rty}), 64'(0));
    idle(1);
    rst = 1'b0;
    m_cyc[0] = 1'b0;
    m_stb[0] = 1'b0;
    fork
      m_xfer(0, 32'h0000_5100, 1'b0, 1, 3'b000, 1'b0, lat0);
      m_xfer(1, 32'h0000_6100, 1'b0, 1, 3'b000, 1'b0, lat1);
    join
    idle(4);

    chk("term_queue_drained", 64'(exp_q.size()), 64'(0));
    chk("gnt_queue_drained", 64'(exp_gnt_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
